// File: rtl/forest_pkg.sv
// rtl/forest_pkg.sv - shared widths, node-word layout, FSM states for the decision forest
package forest_pkg;

   function automatic int at_least_one(int v);
      return (v < 1) ? 1 : v;
   endfunction

   localparam int N_FEAT    = 51;
   localparam int N_NODES   = 32;
   localparam int N_TREES   = 4;
   localparam int N_CLASSES = 2;

   localparam int FEAT_W  = $clog2(N_FEAT);
   localparam int NODE_AW = $clog2(N_NODES);
   localparam int TREE_AW = at_least_one($clog2(N_TREES));
   localparam int CLS_W   = at_least_one($clog2(N_CLASSES));
   localparam int VOTE_W  = $clog2(N_TREES + 1);
   localparam int NODE_W  = 1 + CLS_W + FEAT_W + 2 * NODE_AW;

   // Node word is {leaf, class, feat, hi, lo}, lo in the least significant bits
   localparam int LO_LSB   = 0;
   localparam int HI_LSB   = LO_LSB + NODE_AW;
   localparam int FEAT_LSB = HI_LSB + NODE_AW;
   localparam int CLS_LSB  = FEAT_LSB + FEAT_W;
   localparam int LEAF_BIT = CLS_LSB + CLS_W;

   typedef struct packed {
      logic               leaf;
      logic [CLS_W-1:0]   cls;
      logic [FEAT_W-1:0]  feat;
      logic [NODE_AW-1:0] hi;
      logic [NODE_AW-1:0] lo;
   } node_t;

   typedef enum logic [1:0] {IDLE, WALK, VOTE, DONE} state_t;

   localparam node_t RESET_NODE = '{leaf: 1'b1, cls: '0, feat: '0, hi: '0, lo: '0};

   function automatic node_t node_from_word(logic [NODE_W-1:0] w);
      node_t n;
      n.leaf = w[LEAF_BIT];
      n.cls  = w[CLS_LSB +: CLS_W];
      n.feat = w[FEAT_LSB +: FEAT_W];
      n.hi   = w[HI_LSB +: NODE_AW];
      n.lo   = w[LO_LSB +: NODE_AW];
      return n;
   endfunction

   function automatic logic tree_ok(logic [TREE_AW-1:0] t);
      return 32'(t) < N_TREES;
   endfunction

   function automatic logic cls_ok(logic [CLS_W-1:0] c);
      return 32'(c) < N_CLASSES;
   endfunction

endpackage

// File: rtl/forest_node_ram.sv
// rtl/forest_node_ram.sv - per-tree node table, synchronous write, combinational read
// Reset loads every slot with a class-0 leaf so an unprogrammed forest answers class 0.
module forest_node_ram
   import forest_pkg::*;
(
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               we_i,
   input  logic [TREE_AW-1:0] wtree_i,
   input  logic [NODE_AW-1:0] waddr_i,
   input  logic [NODE_W-1:0]  wdata_i,
   input  logic [TREE_AW-1:0] rtree_i,
   input  logic [NODE_AW-1:0] raddr_i,
   output logic [NODE_W-1:0]  rdata_o
);

   node_t mem_q [N_TREES][N_NODES];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int t = 0; t < N_TREES; t++) begin
            for (int n = 0; n < N_NODES; n++) begin
               mem_q[t][n] <= RESET_NODE;
            end
         end
      end else if (we_i) begin
         mem_q[wtree_i][waddr_i] <= node_from_word(wdata_i);
      end
   end

   assign rdata_o = mem_q[rtree_i][raddr_i];

endmodule

// File: rtl/forest_tree_eval.sv
// rtl/forest_tree_eval.sv - sequential decision-forest evaluator with majority vote
// Walks each tree one node per cycle over a latched feature vector, then returns the argmax.
module forest_tree_eval
   import forest_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [N_FEAT-1:0]  in_feat,
   input  logic               cfg_we,
   input  logic [TREE_AW-1:0] cfg_tree,
   input  logic [NODE_AW-1:0] cfg_addr,
   input  logic [NODE_W-1:0]  cfg_data,
   output logic               cfg_err,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [CLS_W-1:0]   out_class,
   output logic               out_err
);

   state_t                           state_q, state_d;
   logic [N_FEAT-1:0]                feat_q, feat_d;
   logic [TREE_AW-1:0]               tree_q, tree_d;
   logic [NODE_AW-1:0]               node_q, node_d;
   logic [NODE_AW-1:0]               steps_q, steps_d;
   logic [N_CLASSES-1:0][VOTE_W-1:0] votes_q, votes_d;
   logic                             err_q, err_d;
   logic [CLS_W-1:0]                 out_class_q, out_class_d;
   logic                             out_err_q, out_err_d;
   logic                             cfg_err_q, cfg_err_d;

   logic [NODE_W-1:0]     rd_word;
   node_t                 node;
   logic [2**FEAT_W-1:0]  feat_ext;
   logic                  cfg_ok;
   logic                  guard;
   logic [CLS_W-1:0]      vote_cls;
   logic [CLS_W-1:0]      best_cls;
   logic [VOTE_W-1:0]     best_cnt;

   assign cfg_ok = cfg_we && (state_q == IDLE) && tree_ok(cfg_tree);

   forest_node_ram u_ram (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .we_i    (cfg_ok),
      .wtree_i (cfg_tree),
      .waddr_i (cfg_addr),
      .wdata_i (cfg_data),
      .rtree_i (tree_q),
      .raddr_i (node_q),
      .rdata_o (rd_word)
   );

   assign node = node_t'(rd_word);

   // Zero-extend so feature indices past N_FEAT read as 0
   always_comb begin
      feat_ext = '0;
      feat_ext[N_FEAT-1:0] = feat_q;
   end

   // A tree that has taken N_NODES-1 branches without a leaf is cut off as a class-0 vote
   assign guard    = !node.leaf && (steps_q == NODE_AW'(N_NODES - 1));
   assign vote_cls = (guard || !cls_ok(node.cls)) ? '0 : node.cls;

   always_comb begin
      best_cls = '0;
      best_cnt = votes_q[0];
      for (int c = 1; c < N_CLASSES; c++) begin
         if (votes_q[c] > best_cnt) begin
            best_cnt = votes_q[c];
            best_cls = CLS_W'(c);
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      feat_d      = feat_q;
      tree_d      = tree_q;
      node_d      = node_q;
      steps_d     = steps_q;
      votes_d     = votes_q;
      err_d       = err_q;
      out_class_d = out_class_q;
      out_err_d   = out_err_q;
      cfg_err_d   = cfg_we && !cfg_ok;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               feat_d  = in_feat;
               votes_d = '0;
               err_d   = 1'b0;
               tree_d  = '0;
               node_d  = '0;
               steps_d = '0;
               state_d = WALK;
            end
         end
         WALK: begin
            if (node.leaf || guard) begin
               votes_d[vote_cls] = votes_q[vote_cls] + VOTE_W'(1);
               if (guard) err_d = 1'b1;
               node_d  = '0;
               steps_d = '0;
               if (tree_q == TREE_AW'(N_TREES - 1)) state_d = VOTE;
               else tree_d = tree_q + TREE_AW'(1);
            end else begin
               node_d  = feat_ext[node.feat] ? node.hi : node.lo;
               steps_d = steps_q + NODE_AW'(1);
            end
         end
         VOTE: begin
            out_class_d = best_cls;
            out_err_d   = err_q;
            state_d     = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         feat_q      <= '0;
         tree_q      <= '0;
         node_q      <= '0;
         steps_q     <= '0;
         votes_q     <= '0;
         err_q       <= 1'b0;
         out_class_q <= '0;
         out_err_q   <= 1'b0;
         cfg_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         feat_q      <= feat_d;
         tree_q      <= tree_d;
         node_q      <= node_d;
         steps_q     <= steps_d;
         votes_q     <= votes_d;
         err_q       <= err_d;
         out_class_q <= out_class_d;
         out_err_q   <= out_err_d;
         cfg_err_q   <= cfg_err_d;
      end
   end

   assign out_class = out_class_q;
   assign out_err   = out_err_q;
   assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_forest_tree_eval.sv
// tb/tb_forest_tree_eval.sv - randomized bench for forest_tree_eval against a tree-walk model
module tb_forest_tree_eval;
   import forest_pkg::*;

   logic               clk;
   logic               rst_n;
   logic               in_valid;
   logic               in_ready;
   logic [N_FEAT-1:0]  in_feat;
   logic               cfg_we;
   logic [TREE_AW-1:0] cfg_tree;
   logic [NODE_AW-1:0] cfg_addr;
   logic [NODE_W-1:0]  cfg_data;
   logic               cfg_err;
   logic               out_valid;
   logic               out_ready;
   logic [CLS_W-1:0]   out_class;
   logic               out_err;

   int total = 0;
   int bad   = 0;

   // Reference copy of the node table
   bit m_leaf [N_TREES][N_NODES];
   int m_cls  [N_TREES][N_NODES];
   int m_feat [N_TREES][N_NODES];
   int m_hi   [N_TREES][N_NODES];
   int m_lo   [N_TREES][N_NODES];

   forest_tree_eval dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_feat   (in_feat),
      .cfg_we    (cfg_we),
      .cfg_tree  (cfg_tree),
      .cfg_addr  (cfg_addr),
      .cfg_data  (cfg_data),
      .cfg_err   (cfg_err),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_class (out_class),
      .out_err   (out_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic void model_reset();
      for (int t = 0; t < N_TREES; t++)
         for (int n = 0; n < N_NODES; n++) begin
            m_leaf[t][n] = 1'b1; m_cls[t][n] = 0; m_feat[t][n] = 0;
            m_hi[t][n] = 0; m_lo[t][n] = 0;
         end
   endfunction

   // Walk every tree by the node rules, counting one cycle per visited node
   function automatic void model_eval(input logic [N_FEAT-1:0] f, output int cls,
                                      output bit err, output int walk);
      int votes [N_CLASSES];
      int n, steps;
      bit fin, fb;
      foreach (votes[c]) votes[c] = 0;
      err = 1'b0;
      walk = 0;
      for (int t = 0; t < N_TREES; t++) begin
         n = 0; steps = 0; fin = 1'b0;
         while (!fin) begin
            walk++;
            if (m_leaf[t][n]) begin
               votes[(m_cls[t][n] < N_CLASSES) ? m_cls[t][n] : 0]++;
               fin = 1'b1;
            end else if (steps == N_NODES - 1) begin
               votes[0]++;
               err = 1'b1;
               fin = 1'b1;
            end else begin
               fb = 1'b0;
               if (m_feat[t][n] < N_FEAT) fb = f[m_feat[t][n]];
               n = fb ? m_hi[t][n] : m_lo[t][n];
               steps++;
            end
         end
      end
      cls = 0;
      for (int c = 1; c < N_CLASSES; c++) if (votes[c] > votes[cls]) cls = c;
   endfunction

   function automatic logic [N_FEAT-1:0] rand_feat();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      return r[N_FEAT-1:0];
   endfunction

   task automatic do_reset();
      rst_n = 1'b0; in_valid = 1'b0; in_feat = '0; cfg_we = 1'b0;
      cfg_tree = '0; cfg_addr = '0; cfg_data = '0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      model_reset();
   endtask

   task automatic write_node(input int t, input int a, input bit leaf, input int cls,
                             input int ft, input int hi, input int lo);
      cfg_we = 1'b1; cfg_tree = TREE_AW'(t); cfg_addr = NODE_AW'(a);
      cfg_data = {leaf, CLS_W'(cls), FEAT_W'(ft), NODE_AW'(hi), NODE_AW'(lo)};
      @(posedge clk);
      @(negedge clk);
      cfg_we = 1'b0;
      m_leaf[t][a] = leaf; m_cls[t][a] = cls; m_feat[t][a] = ft;
      m_hi[t][a] = hi; m_lo[t][a] = lo;
   endtask

   // Offer a vector from IDLE, count cycles to out_valid, then consume the result
   task automatic run_vec(input logic [N_FEAT-1:0] f, output int lat,
                          output logic [CLS_W-1:0] c, output logic e);
      in_feat = f; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 300) begin
         @(negedge clk);
         lat++;
      end
      c = out_class; e = out_err;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      logic [N_FEAT-1:0] f;
      logic [CLS_W-1:0] c;
      logic e;
      int lat, mc, mw;
      bit me;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
      total++; if (out_class !== '0) begin bad++; $display("FAIL reset_out_class got=%0d want=0", out_class); end
      total++; if (out_err !== 1'b0) begin bad++; $display("FAIL reset_out_err got=%b want=0", out_err); end
      total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL reset_cfg_err got=%b want=0", cfg_err); end
      f = rand_feat();
      model_eval(f, mc, me, mw);
      run_vec(f, lat, c, e);
      total++; if (c !== CLS_W'(mc) || c !== '0) begin bad++; $display("FAIL unconfigured_class got=%0d want=0", c); end
      total++; if (e !== 1'b0) begin bad++; $display("FAIL unconfigured_err got=%b want=0", e); end
      total++; if (lat != N_TREES + 2) begin bad++; $display("FAIL min_latency got=%0d want=%0d", lat, N_TREES + 2); end
   endtask

   task automatic test_feat12();
      logic [N_FEAT-1:0] f;
      logic [CLS_W-1:0] c;
      logic e;
      int lat, mc, mw;
      bit me;
      for (int t = 0; t < N_TREES; t++) begin
         write_node(t, 0, 1'b0, 0, 12, 1, 2);
         write_node(t, 1, 1'b1, 1, 0, 0, 0);
         write_node(t, 2, 1'b1, 0, 0, 0, 0);
      end
      for (int k = 0; k < 4; k++) begin
         f = rand_feat();
         f[12] = k[0];
         model_eval(f, mc, me, mw);
         run_vec(f, lat, c, e);
         total++; if (c !== CLS_W'(mc) || int'(c) != k % 2) begin bad++; $display("FAIL feat12_class bit=%0d got=%0d want=%0d", k % 2, c, mc); end
         total++; if (lat != mw + 2 || lat != 10) begin bad++; $display("FAIL feat12_latency got=%0d want=%0d", lat, mw + 2); end
         total++; if (e !== me) begin bad++; $display("FAIL feat12_err got=%b want=%b", e, me); end
      end
   endtask

   task automatic test_tie();
      logic [CLS_W-1:0] c;
      logic e;
      int lat, mc, mw;
      bit me;
      logic [N_FEAT-1:0] f;
      for (int t = 0; t < N_TREES; t++) write_node(t, 0, 1'b1, (t < 2) ? 1 : 0, 0, 0, 0);
      f = rand_feat();
      model_eval(f, mc, me, mw);
      run_vec(f, lat, c, e);
      total++; if (c !== CLS_W'(mc) || c !== '0) begin bad++; $display("FAIL tie_class got=%0d want=0", c); end
      total++; if (lat != mw + 2) begin bad++; $display("FAIL tie_latency got=%0d want=%0d", lat, mw + 2); end
   endtask

   task automatic test_loop_guard();
      logic [CLS_W-1:0] c;
      logic e;
      int lat, mc, mw;
      bit me;
      logic [N_FEAT-1:0] f;
      write_node(0, 0, 1'b0, 0, $urandom_range(0, 63), 0, 0);
      for (int t = 1; t < N_TREES; t++) write_node(t, 0, 1'b1, 1, 0, 0, 0);
      f = rand_feat();
      model_eval(f, mc, me, mw);
      run_vec(f, lat, c, e);
      total++; if (e !== 1'b1 || me !== 1'b1) begin bad++; $display("FAIL guard_err got=%b want=1", e); end
      total++; if (c !== CLS_W'(mc) || c !== CLS_W'(1)) begin bad++; $display("FAIL guard_class got=%0d want=1", c); end
      total++; if (lat != mw + 2 || lat != N_NODES + (N_TREES - 1) + 2) begin bad++; $display("FAIL guard_latency got=%0d want=%0d", lat, mw + 2); end
   endtask

   task automatic test_write_busy();
      logic [N_FEAT-1:0] f;
      logic [CLS_W-1:0] c0, c1, c2;
      logic e0, e1, e2;
      int lat, mc, mw, n;
      bit me;
      f = rand_feat();
      model_eval(f, mc, me, mw);
      run_vec(f, lat, c0, e0);
      in_feat = f; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL busy_in_ready got=%b want=0", in_ready); end
      cfg_we = 1'b1; cfg_tree = '0; cfg_addr = '0;
      cfg_data = {1'b1, CLS_W'(0), FEAT_W'(0), NODE_AW'(0), NODE_AW'(0)};
      @(posedge clk);
      @(negedge clk);
      cfg_we = 1'b0;
      total++; if (cfg_err !== 1'b1) begin bad++; $display("FAIL busy_cfg_err_pulse got=%b want=1", cfg_err); end
      @(negedge clk);
      total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL busy_cfg_err_clear got=%b want=0", cfg_err); end
      n = 0;
      while (!out_valid && n < 300) begin @(negedge clk); n++; end
      c1 = out_class; e1 = out_err;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      total++; if (c1 !== c0 || c1 !== CLS_W'(mc)) begin bad++; $display("FAIL busy_class got=%0d want=%0d", c1, mc); end
      total++; if (e1 !== e0 || e1 !== me) begin bad++; $display("FAIL busy_err got=%b want=%b", e1, me); end
      run_vec(f, lat, c2, e2);
      total++; if (c2 !== CLS_W'(mc) || lat != mw + 2) begin bad++; $display("FAIL busy_table_kept class=%0d lat=%0d want class=%0d lat=%0d", c2, lat, mc, mw + 2); end
      // Write and accept in the same IDLE cycle: the new root is used
      cfg_we = 1'b1; cfg_tree = '0; cfg_addr = '0;
      cfg_data = {1'b1, CLS_W'(1), FEAT_W'(0), NODE_AW'(0), NODE_AW'(0)};
      in_feat = f; in_valid = 1'b1;
      m_leaf[0][0] = 1'b1; m_cls[0][0] = 1;
      model_eval(f, mc, me, mw);
      @(posedge clk);
      @(negedge clk);
      cfg_we = 1'b0; in_valid = 1'b0;
      total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL same_cycle_cfg_err got=%b want=0", cfg_err); end
      n = 1;
      while (!out_valid && n < 300) begin @(negedge clk); n++; end
      total++; if (out_class !== CLS_W'(mc) || out_err !== me || n != mw + 2) begin bad++; $display("FAIL same_cycle class=%0d err=%b lat=%0d want %0d %b %0d", out_class, out_err, n, mc, me, mw + 2); end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_random();
      logic [N_FEAT-1:0] f;
      logic [CLS_W-1:0] c;
      logic e;
      int lat, mc, mw;
      bit me;
      for (int r = 0; r < 4; r++) begin
         for (int t = 0; t < N_TREES; t++)
            for (int a = 0; a < N_NODES; a++)
               write_node(t, a, ($urandom_range(0, 9) < 4), $urandom_range(0, (1 << CLS_W) - 1),
                          $urandom_range(0, (1 << FEAT_W) - 1), $urandom_range(0, N_NODES - 1),
                          $urandom_range(0, N_NODES - 1));
         for (int v = 0; v < 4; v++) begin
            f = rand_feat();
            model_eval(f, mc, me, mw);
            run_vec(f, lat, c, e);
            total++; if (c !== CLS_W'(mc) || e !== me) begin bad++; $display("FAIL random_result r=%0d v=%0d got=%0d/%b want=%0d/%b", r, v, c, e, mc, me); end
            total++; if (lat != mw + 2) begin bad++; $display("FAIL random_latency r=%0d v=%0d got=%0d want=%0d", r, v, lat, mw + 2); end
         end
      end
   endtask

   task automatic test_backpressure_reset();
      logic [N_FEAT-1:0] f;
      logic [CLS_W-1:0] c;
      logic e;
      int lat, mc, mw, n;
      bit me;
      f = rand_feat();
      model_eval(f, mc, me, mw);
      in_feat = f; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      n = 1;
      while (!out_valid && n < 300) begin @(negedge clk); n++; end
      for (int k = 0; k < 5; k++) begin
         total++; if (out_valid !== 1'b1 || out_class !== CLS_W'(mc) || out_err !== me) begin bad++; $display("FAIL hold_stable k=%0d valid=%b class=%0d err=%b want class=%0d err=%b", k, out_valid, out_class, out_err, mc, me); end
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL after_handshake in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
      write_node(0, 0, 1'b0, 0, 7, 0, 0);
      write_node(1, 0, 1'b1, 1, 0, 0, 0);
      in_feat = f; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_class !== '0 || out_err !== 1'b0) begin bad++; $display("FAIL mid_reset valid=%b ready=%b class=%0d err=%b want 0/1/0/0", out_valid, in_ready, out_class, out_err); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      model_reset();
      f = rand_feat();
      model_eval(f, mc, me, mw);
      run_vec(f, lat, c, e);
      total++; if (c !== '0 || e !== 1'b0 || lat != N_TREES + 2 || lat != mw + 2) begin bad++; $display("FAIL table_restored class=%0d err=%b lat=%0d want 0/0/%0d", c, e, lat, N_TREES + 2); end
   endtask

   initial begin
      do_reset();
      test_reset();
      test_feat12();
      test_tie();
      test_loop_guard();
      test_write_busy();
      test_random();
      test_backpressure_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
